// File: rtl/pc_btb_if.sv
// Fetch-side bundle for pc_btb: stall/redirect/training inputs and the
// predicted fetch address outputs.
interface pc_btb_if #(
  parameter int XLEN = 32
);
  logic            pause;
  logic            fetch_rvc;
  logic            redirect;
  logic [XLEN-1:0] redirect_pc;
  logic            upd_valid;
  logic [XLEN-1:0] upd_pc;
  logic [XLEN-1:0] upd_target;
  logic            upd_taken;
  logic            upd_jump;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] npc;
  logic            pred_taken;

  modport master (
    output pause, fetch_rvc, redirect, redirect_pc,
    output upd_valid, upd_pc, upd_target, upd_taken, upd_jump,
    input  pc, npc, pred_taken
  );

  modport slave (
    input  pause, fetch_rvc, redirect, redirect_pc,
    input  upd_valid, upd_pc, upd_target, upd_taken, upd_jump,
    output pc, npc, pred_taken
  );
endinterface

// File: rtl/pc_btb.sv
// Fetch PC register with a direct-mapped BTB and 2-bit direction counters;
// predicts npc combinationally and trains from EX-resolved branches.
module pc_btb #(
  parameter int              XLEN    = 32,
  parameter logic [XLEN-1:0] RESET   = '0,
  parameter int              ENTRIES = 16
) (
  input logic   clock,
  input logic   reset,
  pc_btb_if.slave bus
);
  localparam int IDX   = $clog2(ENTRIES);
  localparam int TAG_W = XLEN - IDX - 1;

  function automatic logic [1:0] ctr_inc(input logic [1:0] c);
    return (c == 2'd3) ? c : c + 2'd1;
  endfunction

  function automatic logic [1:0] ctr_dec(input logic [1:0] c);
    return (c == 2'd0) ? c : c - 2'd1;
  endfunction

  logic [XLEN-1:0]  pc_q, pc_d;
  logic [ENTRIES-1:0] valid_q, valid_d;
  logic [ENTRIES-1:0] jump_q, jump_d;
  logic [1:0]       ctr_q    [ENTRIES];
  logic [1:0]       ctr_d    [ENTRIES];
  logic [TAG_W-1:0] tag_q    [ENTRIES];
  logic [TAG_W-1:0] tag_d    [ENTRIES];
  logic [XLEN-1:0]  target_q [ENTRIES];
  logic [XLEN-1:0]  target_d [ENTRIES];

  logic [IDX-1:0]   fetch_idx, upd_idx;
  logic [TAG_W-1:0] fetch_tag, upd_tag;
  logic             fetch_hit, upd_hit, pred_taken;
  logic [XLEN-1:0]  npc;
  logic             unused_lsbs;

  // Lookup: halfword-granular index so RVC instructions get their own slots
  assign fetch_idx  = pc_q[IDX:1];
  assign fetch_tag  = pc_q[XLEN-1:IDX+1];
  assign fetch_hit  = valid_q[fetch_idx] && (tag_q[fetch_idx] == fetch_tag);
  assign pred_taken = fetch_hit && (jump_q[fetch_idx] || ctr_q[fetch_idx][1]);
  assign npc        = pred_taken ? target_q[fetch_idx]
                                 : pc_q + (bus.fetch_rvc ? XLEN'(2) : XLEN'(4));

  assign upd_idx = bus.upd_pc[IDX:1];
  assign upd_tag = bus.upd_pc[XLEN-1:IDX+1];
  assign upd_hit = valid_q[upd_idx] && (tag_q[upd_idx] == upd_tag);

  assign unused_lsbs = ^{bus.upd_pc[0], bus.upd_target[0], bus.redirect_pc[0]};

  always_comb begin
    pc_d = pc_q;
    if (bus.redirect) begin
      pc_d = {bus.redirect_pc[XLEN-1:1], 1'b0};
    end else if (!bus.pause) begin
      pc_d = npc;
    end
  end

  // Training sees the pre-edge table; no bypass into this cycle's lookup
  always_comb begin
    valid_d  = valid_q;
    jump_d   = jump_q;
    ctr_d    = ctr_q;
    tag_d    = tag_q;
    target_d = target_q;
    if (bus.upd_valid) begin
      if (upd_hit) begin
        ctr_d[upd_idx]  = bus.upd_taken ? ctr_inc(ctr_q[upd_idx]) : ctr_dec(ctr_q[upd_idx]);
        jump_d[upd_idx] = bus.upd_jump;
        if (bus.upd_taken) begin
          target_d[upd_idx] = {bus.upd_target[XLEN-1:1], 1'b0};
        end
      end else if (bus.upd_taken) begin
        valid_d[upd_idx]  = 1'b1;
        tag_d[upd_idx]    = upd_tag;
        target_d[upd_idx] = {bus.upd_target[XLEN-1:1], 1'b0};
        jump_d[upd_idx]   = bus.upd_jump;
        ctr_d[upd_idx]    = 2'd2;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q    <= RESET;
      valid_q <= '0;
      for (int i = 0; i < ENTRIES; i++) ctr_q[i] <= 2'd1;
    end else begin
      pc_q    <= pc_d;
      valid_q <= valid_d;
      ctr_q   <= ctr_d;
    end
  end

  // Payload is qualified by valid_q, so it carries no reset
  always_ff @(posedge clock) begin
    jump_q   <= jump_d;
    tag_q    <= tag_d;
    target_q <= target_d;
  end

  assign bus.pc         = pc_q;
  assign bus.npc        = npc;
  assign bus.pred_taken = pred_taken;
endmodule

// File: doc/pc_btb.md
# pc_btb

Fetch-stage program counter with a direct-mapped branch target buffer (BTB) and 2-bit saturating direction counters. It is the parametrised successor to the plain PC register and next-address adder. It predicts the next fetch address from the current PC, accepts mispredict redirects from EX, and trains the BTB from resolved branches and jumps. It sits between the instruction fetch port and the EX-stage branch resolution logic, and supports RVC (16-bit) instructions.

## Interface
- XLEN, 32, address width
- RESET, 0, PC value loaded on reset
- ENTRIES, 16, number of BTB entries; power of two, at least 2; IDX = log2(ENTRIES)

- clock  in  1  clock
- reset  in  1  synchronous, active-high reset; clock clock
- pause  in  1  fetch stall; holds pc
- fetch_rvc  in  1  instruction at pc is compressed (16-bit)
- redirect  in  1  EX detected a mispredict; load redirect_pc
- redirect_pc  in  XLEN  correct next PC from EX
- upd_valid  in  1  a branch or jump resolved in EX this cycle
- upd_pc  in  XLEN  PC of the resolved instruction
- upd_target  in  XLEN  resolved target address
- upd_taken  in  1  resolved direction (always 1 for jumps)
- upd_jump  in  1  resolved instruction is unconditional (jal/jalr)
- pc  out  XLEN  current fetch PC
- npc  out  XLEN  predicted next PC (combinational)
- pred_taken  out  1  npc came from the BTB; pipelined with the instruction so EX can compare

## Operation
- Index is pc[IDX:1] (halfword granularity). Tag is pc[XLEN-1:IDX+1].
- Each entry holds:
  - valid: 1 bit
  - tag: XLEN-IDX-1 bits
  - target: XLEN bits, bit 0 always stored as 0
  - jump: 1 bit
  - ctr: 2 bits
- Lookup is combinational on pc. A hit means valid is set and the tag matches.
- pred_taken = hit && (jump || ctr[1]).
- npc = pred_taken ? target : pc + (fetch_rvc ? 2 : 4). The sum wraps modulo 2^XLEN.
- PC register priority, evaluated each clock edge:
  1. reset: pc <= RESET
  2. redirect: pc <= redirect_pc with bit 0 cleared; redirect overrides pause
  3. !pause: pc <= npc
  4. otherwise hold
- Training applies on every edge where upd_valid is set and reset is low; pause does not block it. The entry is selected by upd_pc's index and tag.
  - Hit, taken: ctr saturates up (max 3); target <= upd_target; jump <= upd_jump.
  - Hit, not taken: ctr saturates down (min 0); target is unchanged; jump <= upd_jump.
  - Miss, taken: allocate or overwrite the entry. valid=1, tag written, target=upd_target, jump=upd_jump, ctr=2 (weakly taken).
  - Miss, not taken: no change.
- Reset clears every valid bit and sets every ctr to 1. Target and tag are don't-care after reset.
- redirect and upd_valid are independent. Both may be asserted in the same cycle and both take effect.

## Timing
- Reset values: pc = RESET. With the BTB empty, pred_taken = 0 and npc = RESET + 4 (or + 2 if fetch_rvc).
- npc and pred_taken follow pc, table state and fetch_rvc within the same cycle; zero latency.
- pc updates one cycle after the controlling input: redirect_pc is visible on pc the following cycle.
- A BTB write is visible to lookup on the cycle after the update edge.
- There is no same-cycle bypass. A lookup at the index being trained this cycle sees the old contents.
- If reset and upd_valid are asserted together, reset wins and the table is cleared.
- If reset is asserted mid-stream, pc returns to RESET on the next edge regardless of pause or redirect.

## Test plan
- Reset with RESET=0x100: after release, pc steps 0x100→0x104→0x108. With fetch_rvc=1 at 0x108, the next pc is 0x10A. pred_taken stays 0 throughout.
- Pause: assert pause for 3 cycles at pc=0x104 → pc holds 0x104. Assert redirect=1 with redirect_pc=0x201 during pause → pc=0x200 on the next cycle.
- Train a taken branch: upd_pc=0x110, upd_target=0x180, taken=1, jump=0. Then fetch 0x110 → pred_taken=1, npc=0x180 (ctr=2). Two not-taken updates → ctr=0, pred_taken=0, npc=0x114.
- Counter saturation: four taken updates on one entry → ctr=3. One not-taken update → ctr=2, prediction still taken.
- Jump entry: train with upd_jump=1, then a not-taken update with upd_jump=1 → pred_taken stays 1. Aliasing: ENTRIES=16, train 0x110, then fetch 0x130 (same index, different tag) → miss, npc=0x134.
- Simultaneous training and lookup: upd_valid at the index currently in pc → this cycle's npc uses the old entry; the new entry is visible the following cycle. reset together with upd_valid → table empty afterward.
